disp_page_ctrl: RTL

Upstream feeder for the 4-digit 7-segment hex display driver.
- Holds the 64-bit snapshot presented on disp_reg.
- Produces the 2-bit page select disp_ctrl, which picks one 16-bit quarter of disp_reg.
- Page select is stepped by two debounced push-buttons (next/prev); a synchronized freeze switch holds the snapshot for reading.
- Sits between the debug/datapath sources and the display driver, in the display clock domain.

---
 rtl/disp_pkg.sv | 17 +
 rtl/btn_debounce.sv | 50 +++++
 rtl/disp_page_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared display definitions for the page controller and the 7-segment driver.
package disp_pkg;

    localparam int unsigned DISP_PAGES   = 4;
    localparam int unsigned DISP_PAGE_W  = 2;
    localparam int unsigned DISP_DATA_W  = 64;
    localparam int unsigned DISP_DIGIT_W = 16;

    typedef logic [DISP_PAGE_W-1:0] disp_page_t;
    typedef logic [DISP_DATA_W-1:0] disp_data_t;

    // One page step up or down; the page width makes the wrap across DISP_PAGES implicit.
    function automatic disp_page_t page_step(input disp_page_t cur, input logic up);
        return up ? cur + disp_page_t'(1) : cur - disp_page_t'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted 0->1 level change.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_pulse    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_pulse    <= r_stable & ~r_stable_d;
            // Count only while the synchronized level disagrees with the accepted one
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level       = r_stable;
    assign press_pulse = r_pulse;

endmodule

// File: rtl/disp_page_ctrl.sv
// Snapshot register and page select feeding the 4-digit hex display driver.
// Define DISP_AUTO_SCROLL_EN to add periodic auto-advance of the page select.
module disp_page_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 1000000,
    parameter int unsigned SCROLL_CYCLES = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_next,
    input  logic                   btn_prev,
    input  logic                   freeze,
    input  logic [DISP_DATA_W-1:0] data_in,
    input  logic                   data_valid,
    output logic [DISP_DATA_W-1:0] disp_reg,
    output logic [DISP_PAGE_W-1:0] disp_ctrl,
    output logic                   page_pulse
);

    logic       w_next_ev;
    logic       w_prev_ev;
    logic       w_next_level;
    logic       w_prev_level;
    logic       w_unused_levels;
    logic       w_scroll_tick;
    disp_page_t w_page_nxt;
    logic       r_frz_s1;
    logic       r_frz_s2;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clk         (clk),
        .rst         (rst),
        .raw         (btn_next),
        .level       (w_next_level),
        .press_pulse (w_next_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
        .clk         (clk),
        .rst         (rst),
        .raw         (btn_prev),
        .level       (w_prev_level),
        .press_pulse (w_prev_ev)
    );

    assign w_unused_levels = w_next_level ^ w_prev_level;

`ifdef DISP_AUTO_SCROLL_EN
    localparam int unsigned SCROLL_W = $clog2(SCROLL_CYCLES);

    logic [SCROLL_W-1:0] r_scroll_cnt;

    assign w_scroll_tick = !r_frz_s2 && (r_scroll_cnt == SCROLL_W'(SCROLL_CYCLES - 1));

    // Button events restart the period; freeze parks the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scroll_cnt <= '0;
        end else if (w_next_ev || w_prev_ev) begin
            r_scroll_cnt <= '0;
        end else if (!r_frz_s2) begin
            r_scroll_cnt <= w_scroll_tick ? '0 : r_scroll_cnt + SCROLL_W'(1);
        end
    end
`else
    logic w_unused_scroll;

    assign w_scroll_tick   = 1'b0;
    assign w_unused_scroll = ^SCROLL_CYCLES;
`endif

    // Simultaneous next/prev cancel out and also swallow a coincident scroll tick
    always_comb begin
        w_page_nxt = disp_ctrl;
        if (w_next_ev && !w_prev_ev) begin
            w_page_nxt = page_step(disp_ctrl, 1'b1);
        end else if (w_prev_ev && !w_next_ev) begin
            w_page_nxt = page_step(disp_ctrl, 1'b0);
        end else if (!w_next_ev && !w_prev_ev && w_scroll_tick) begin
            w_page_nxt = page_step(disp_ctrl, 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frz_s1   <= 1'b0;
            r_frz_s2   <= 1'b0;
            disp_reg   <= '0;
            disp_ctrl  <= '0;
            page_pulse <= 1'b0;
        end else begin
            r_frz_s1   <= freeze;
            r_frz_s2   <= r_frz_s1;
            disp_ctrl  <= w_page_nxt;
            page_pulse <= (w_page_nxt != disp_ctrl);
            if (data_valid && !r_frz_s2) begin
                disp_reg <= data_in;
            end
        end
    end

endmodule
